// File: rtl/loopback_checker.sv
// Bit-slip aligner and incrementing-counter pattern checker for the HPIO RX loopback word stream.
// Optional CHK_BITERR_CNT_EN adds a bit-level error counter on bad compares while locked.
module loopback_checker #(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic [7:0]       aligned_data,
    output logic             aligned_valid,
    output logic [2:0]       slip_offset,
    output logic             locked,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count,
    output logic             lock_loss
`ifdef CHK_BITERR_CNT_EN
    ,
    output logic [CNT_W-1:0] bit_err_count
`endif
);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t     state_q, state_d;
    logic [7:0] prev_q, ref_q, ref_d;
    logic [7:0] good_cnt_q, good_d, bad_cnt_q, bad_d;
    logic [2:0] k_q, k_d;
    logic       primed_q, has_ref_q, has_ref_d;
    logic       window, good, err_inc, word_inc, loss_d;
    logic [15:0] cat;
    logic [7:0]  win;

    // The window straddles the previous and current raw words; k=0 selects the previous word.
    assign cat    = {data_in, prev_q};
    assign win    = 8'(cat >> k_q);
    assign window = data_valid && primed_q;
    assign good   = has_ref_q && (win == ref_q + 8'd1);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        ref_d     = ref_q;
        has_ref_d = has_ref_q;
        good_d    = good_cnt_q;
        bad_d     = bad_cnt_q;
        err_inc   = 1'b0;
        word_inc  = 1'b0;
        loss_d    = 1'b0;
        if (window) begin
            ref_d     = win;
            has_ref_d = 1'b1;
            case (state_q)
                SEARCH: begin
                    if (has_ref_q) begin
                        if (good) begin
                            if (LOCK_COUNT <= 1) begin
                                state_d = LOCKED;
                            end else begin
                                state_d = VERIFY;
                                good_d  = 8'd1;
                            end
                        end else begin
                            k_d       = k_q + 3'd1;
                            has_ref_d = 1'b0;
                        end
                    end
                end
                VERIFY: begin
                    if (good) begin
                        if (9'({1'b0, good_cnt_q} + 9'd1) >= 9'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            good_d  = 8'd0;
                        end else begin
                            good_d = good_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d   = SEARCH;
                        k_d       = k_q + 3'd1;
                        has_ref_d = 1'b0;
                        good_d    = 8'd0;
                    end
                end
                LOCKED: begin
                    word_inc = 1'b1;
                    if (good) begin
                        bad_d = 8'd0;
                    end else begin
                        err_inc = 1'b1;
                        if (9'({1'b0, bad_cnt_q} + 9'd1) >= 9'(UNLOCK_COUNT)) begin
                            state_d   = SEARCH;
                            k_d       = k_q + 3'd1;
                            has_ref_d = 1'b0;
                            bad_d     = 8'd0;
                            loss_d    = 1'b1;
                        end else begin
                            bad_d = bad_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SEARCH;
            k_q           <= 3'd0;
            prev_q        <= 8'd0;
            ref_q         <= 8'd0;
            has_ref_q     <= 1'b0;
            primed_q      <= 1'b0;
            good_cnt_q    <= 8'd0;
            bad_cnt_q     <= 8'd0;
            aligned_data  <= 8'd0;
            aligned_valid <= 1'b0;
            lock_loss     <= 1'b0;
            err_count     <= '0;
            word_count    <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            ref_q         <= ref_d;
            has_ref_q     <= has_ref_d;
            good_cnt_q    <= good_d;
            bad_cnt_q     <= bad_d;
            aligned_valid <= window;
            lock_loss     <= loss_d;
            if (data_valid) begin
                prev_q   <= data_in;
                primed_q <= 1'b1;
            end
            if (window) aligned_data <= win;
            if (err_inc && !(&err_count)) err_count <= err_count + ONE;
            if (word_inc && !(&word_count)) word_count <= word_count + ONE;
        end
    end

    assign slip_offset = k_q;
    assign locked      = (state_q == LOCKED);

`ifdef CHK_BITERR_CNT_EN
    logic [3:0]   pc_q;
    logic         pc_vld_q;
    logic [CNT_W:0] bit_sum;

    // Popcount is registered first so the wide saturating add sits alone in the next stage.
    assign bit_sum = {1'b0, bit_err_count} + (CNT_W+1)'(pc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= 4'd0;
            pc_vld_q      <= 1'b0;
            bit_err_count <= '0;
        end else begin
            pc_vld_q <= err_inc;
            pc_q     <= 4'($countones(win ^ (ref_q + 8'd1)));
            if (pc_vld_q) bit_err_count <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_loopback_checker.sv
// Self-checking bench for loopback_checker: directed vector table, hand sequences from the
// test plan, and randomized traffic checked every cycle against a per-beat reference model.
module tb_loopback_checker;

    localparam int LC = 16;
    localparam int UC = 4;
    localparam int CW = 32;
    localparam longint SAT = (longint'(1) << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, data_valid;
    logic [7:0]    data_in;
    logic [7:0]    aligned_data;
    logic          aligned_valid, locked, lock_loss;
    logic [2:0]    slip_offset;
    logic [CW-1:0] err_count, word_count;
`ifdef CHK_BITERR_CNT_EN
    logic [CW-1:0] bit_err_count;
`endif

    loopback_checker #(.LOCK_COUNT(LC), .UNLOCK_COUNT(UC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .aligned_data(aligned_data), .aligned_valid(aligned_valid), .slip_offset(slip_offset),
        .locked(locked), .err_count(err_count), .word_count(word_count), .lock_loss(lock_loss)
`ifdef CHK_BITERR_CNT_EN
        , .bit_err_count(bit_err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: mode 0 hunting, 1 confirming, 2 locked.
    int     m_prev, m_ref, m_k, m_mode, m_run, m_miss, m_stage;
    bit     m_primed, m_has_ref, m_stage_v;
    longint m_err, m_words, m_bit;
    int     e_ad;
    bit     e_av, e_loss;

    function automatic longint sat_add(longint x, longint a);
        return (x + a > SAT) ? SAT : x + a;
    endfunction

    function automatic int popc8(int x);
        int c = 0;
        for (int i = 0; i < 8; i++) c += (x >> i) & 1;
        return c;
    endfunction

    task automatic m_step(input bit r, input bit v, input int d);
        int win, expect_w, pc;
        bit ok, hadref, newbad;
        e_loss = 0;
        e_av   = 0;
        if (r) begin
            m_prev = 0; m_ref = 0; m_k = 0; m_mode = 0; m_run = 0; m_miss = 0;
            m_primed = 0; m_has_ref = 0; m_err = 0; m_words = 0; m_bit = 0;
            m_stage = 0; m_stage_v = 0; e_ad = 0;
            return;
        end
        newbad = 0;
        pc = 0;
        if (v) begin
            if (m_primed) begin
                win      = ((d * 256 + m_prev) >> m_k) % 256;
                expect_w = (m_ref + 1) % 256;
                hadref   = m_has_ref;
                ok       = hadref && (win == expect_w);
                e_av = 1;
                e_ad = win;
                m_ref = win;
                m_has_ref = 1;
                if (!hadref) begin
                end else if (m_mode == 2) begin
                    m_words = sat_add(m_words, 1);
                    if (ok) m_miss = 0;
                    else begin
                        m_err = sat_add(m_err, 1);
                        newbad = 1;
                        pc = popc8(win ^ expect_w);
                        m_miss++;
                        if (m_miss == UC) begin
                            m_mode = 0; m_miss = 0; e_loss = 1;
                            m_k = (m_k + 1) % 8; m_has_ref = 0;
                        end
                    end
                end else if (ok) begin
                    m_run++;
                    if (m_run >= LC) begin m_mode = 2; m_run = 0; end
                    else m_mode = 1;
                end else begin
                    m_mode = 0; m_run = 0;
                    m_k = (m_k + 1) % 8; m_has_ref = 0;
                end
            end
            m_primed = 1;
            m_prev = d % 256;
        end
        if (m_stage_v) m_bit = sat_add(m_bit, m_stage);
        m_stage_v = newbad;
        m_stage = pc;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("aligned_valid", 64'(aligned_valid), 64'(e_av));
        chk("aligned_data", 64'(aligned_data), 64'(e_ad));
        chk("slip_offset", 64'(slip_offset), 64'(m_k));
        chk("locked", 64'(locked), 64'(m_mode == 2));
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("word_count", 64'(word_count), 64'(m_words));
        chk("lock_loss", 64'(lock_loss), 64'(e_loss));
`ifdef CHK_BITERR_CNT_EN
        chk("bit_err_count", 64'(bit_err_count), 64'(m_bit));
`endif
    endtask

    task automatic cyc(input bit r, input bit v, input int d);
        @(negedge clk);
        rst = r;
        data_valid = v;
        data_in = 8'(d);
        @(posedge clk);
        m_step(r, v, d);
        #1;
        check_all();
    endtask

    // Counter words n = start..start+n-1; rot!=0 shifts the bitstream so alignment sits at offset rot.
    task automatic cnt_beats(input int start, input int n, input int rot);
        int c, p;
        for (int i = 0; i < n; i++) begin
            c = (start + i) % 256;
            p = (start + i + 255) % 256;
            cyc(0, 1, (rot == 0) ? c : ((c * 256 + p) >> (8 - rot)) % 256);
        end
    endtask

    typedef struct {
        bit         r;
        bit         v;
        logic [7:0] d;
        bit         eav;
        logic [7:0] ead;
        logic [2:0] eslip;
        bit         elock;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int pulses, a1, pos, rot, seg, mode;
        rst = 1; data_valid = 0; data_in = 0;

        tbl[0] = '{1, 0, 8'h00, 0, 8'h00, 3'd0, 0};
        tbl[1] = '{0, 1, 8'h00, 0, 8'h00, 3'd0, 0};
        tbl[2] = '{0, 1, 8'h01, 1, 8'h00, 3'd0, 0};
        tbl[3] = '{0, 0, 8'h55, 0, 8'h00, 3'd0, 0};
        tbl[4] = '{0, 1, 8'h02, 1, 8'h01, 3'd0, 0};
        tbl[5] = '{0, 1, 8'h03, 1, 8'h02, 3'd0, 0};
        tbl[6] = '{0, 1, 8'h07, 1, 8'h03, 3'd0, 0};
        tbl[7] = '{0, 1, 8'h08, 1, 8'h07, 3'd1, 0};
        tbl[8] = '{0, 1, 8'h09, 1, 8'h84, 3'd1, 0};
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].r, tbl[i].v, int'(tbl[i].d));
            chk($sformatf("tbl%0d_av", i), 64'(aligned_valid), 64'(tbl[i].eav));
            chk($sformatf("tbl%0d_ad", i), 64'(aligned_data), 64'(tbl[i].ead));
            chk($sformatf("tbl%0d_slip", i), 64'(slip_offset), 64'(tbl[i].eslip));
            chk($sformatf("tbl%0d_lock", i), 64'(locked), 64'(tbl[i].elock));
        end

        // Aligned counter: lock after beat 18, then a single corrupted word costs two errors.
        cyc(1, 0, 0);
        chk("reset_locked", 64'(locked), 64'd0);
        cnt_beats(0, 17, 0);
        chk("pre_lock", 64'(locked), 64'd0);
        cnt_beats(17, 1, 0);
        chk("lock_at_18", 64'(locked), 64'd1);
        chk("lock_slip0", 64'(slip_offset), 64'd0);
        cnt_beats(18, 46, 0);
        chk("words_46", 64'(word_count), 64'd46);
        cyc(0, 1, 8'h41);
        cnt_beats(8'h41, 16, 0);
        chk("corrupt_err2", 64'(err_count), 64'd2);
        chk("corrupt_locked", 64'(locked), 64'd1);

        // Constant 0xA5 while locked.
        cyc(1, 0, 0);
        cnt_beats(0, 30, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 8'hA5);
            pulses += int'(lock_loss);
        end
        chk("a5_pulses", 64'(pulses), 64'd1);
        chk("a5_locked", 64'(locked), 64'd0);
        chk("a5_err4", 64'(err_count), 64'd4);
        chk("a5_slip1", 64'(slip_offset), 64'd1);

        // Stream rotated so the counter sits at offset 5.
        cyc(1, 0, 0);
        cnt_beats(0, 200, 5);
        chk("rot5_slip", 64'(slip_offset), 64'd5);
        chk("rot5_locked", 64'(locked), 64'd1);
        a1 = int'(aligned_data);
        cnt_beats(200, 1, 5);
        chk("rot5_inc", 64'(aligned_data), 64'((a1 + 1) % 256));

        // Valid toggling: idle cycles change nothing.
        cyc(1, 0, 0);
        for (int i = 0; i < 18; i++) begin
            cyc(0, 1, i);
            if (i == 16) chk("tog_pre_lock", 64'(locked), 64'd0);
            if (i == 17) chk("tog_lock", 64'(locked), 64'd1);
            cyc(0, 0, 8'hFF);
        end

        // Reset while locked with three errors.
        cyc(1, 0, 0);
        cnt_beats(0, 64, 0);
        cyc(0, 1, 8'h41);
        cnt_beats(8'h41, 5, 0);
        cnt_beats(8'h47, 4, 0);
        chk("pre_rst_err3", 64'(err_count), 64'd3);
        cyc(1, 0, 0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_words", 64'(word_count), 64'd0);
        chk("rst_slip", 64'(slip_offset), 64'd0);
        chk("rst_av", 64'(aligned_valid), 64'd0);

        // Randomized segments of noise, rotated counters and corrupted counters.
        pos = 0;
        for (int s = 0; s < 40; s++) begin
            mode = int'($urandom_range(0, 2));
            rot  = int'($urandom_range(0, 7));
            seg  = int'($urandom_range(20, 90));
            for (int i = 0; i < seg; i++) begin
                int c, p, d;
                bit v, r;
                r = ($urandom_range(0, 399) == 0);
                v = ($urandom_range(0, 99) < 85);
                c = pos % 256;
                p = (pos + 255) % 256;
                if (mode == 0) d = int'($urandom_range(0, 255));
                else begin
                    d = (rot == 0) ? c : ((c * 256 + p) >> (8 - rot)) % 256;
                    if (mode == 2 && $urandom_range(0, 29) == 0) d = d ^ (1 << $urandom_range(0, 7));
                end
                cyc(r, v, d);
                if (v) pos++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
